// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and helpers for the FIFO control blocks.
package fifo_ctrl_pkg;

  // Arbiter state encoding
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  // Default beat width, matching the FIFO wr_data width
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: returns the first set request after ptr_i,
// wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
module rr_picker
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [PW-1:0]      idx_o,
  output logic               any_o
);

  // Scan ptr+1, ptr+2, ... and keep the first valid requester found
  always_comb begin
    int j;
    j     = 0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_o && req_i[PW'(j)]) begin
        any_o = 1'b1;
        idx_o = PW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-port arbiter for the async FIFO: round-robin among NUM_REQ producers,
// with the winner holding the port until its last beat or MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_BURST  = 4,
  localparam int GW        = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1,
  localparam int CW        = clog2(MAX_BURST + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_wr_en,
  output logic [DATA_WIDTH-1:0]        fifo_wr_data,
  output logic [GW-1:0]                grant_id,
  output logic                         busy
);

  logic            state_q;
  logic [GW-1:0]   rr_ptr_q;
  logic [GW-1:0]   owner_q;
  logic [CW-1:0]   beat_cnt_q;
  logic [GW-1:0]   grant_id_q;
  logic            busy_q;

  logic [GW-1:0]   pick_idx;
  logic            pick_any;
  logic [GW-1:0]   sel;
  logic            sel_valid;
  logic            sel_last;
  logic            xfer;
  logic            burst_end;
  logic [CW-1:0]   beat_cnt_inc;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (GW)
  ) u_picker (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Split the flat data bus into one beat per requester
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data
    assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // While locked only the owner may transfer; otherwise the round-robin pick
  assign sel       = (state_q == ST_LOCKED) ? owner_q : pick_idx;
  assign sel_valid = (state_q == ST_LOCKED) ? req_valid[owner_q] : pick_any;
  assign sel_last  = req_last[sel];

  // Reset gates the strobe combinationally so nothing is written while rst is high
  assign xfer = sel_valid & ~fifo_full & ~rst;

  // In IDLE beat_cnt is 0, so MAX_BURST==1 ends every burst on its first beat
  assign beat_cnt_inc = beat_cnt_q + CW'(1);
  assign burst_end    = sel_last | (beat_cnt_inc == CW'(MAX_BURST));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = xfer & (sel == GW'(gi));
  end

  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = data_arr[sel];
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;

  // Arbitration FSM: lock on a non-final beat, release on last or burst limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= GW'(NUM_REQ - 1);
      owner_q    <= '0;
      beat_cnt_q <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else if (xfer) begin
      grant_id_q <= sel;
      if (burst_end) begin
        state_q    <= ST_IDLE;
        busy_q     <= 1'b0;
        rr_ptr_q   <= sel;
        beat_cnt_q <= '0;
      end else begin
        state_q    <= ST_LOCKED;
        busy_q     <= 1'b1;
        owner_q    <= sel;
        beat_cnt_q <= beat_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues feed the DUT, a
// grant-level reference model predicts each cycle, a monitor compares.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [1:0]      grant_id;
  logic            busy;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  typedef struct {
    bit wr;
    int idx;
    int grant;
    bit busy;
  } stat_t;

  beat_t          prod_q [N][$];
  bit             hold [N];
  stat_t          stat_q [$];
  logic [DW-1:0]  wdata_q [$];

  // Reference model: who holds the port, beats granted so far, last winner
  int m_owner;
  int m_beats;
  int m_last;
  int m_grant;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = N - 1;
    m_grant = 0;
    for (int r = 0; r < N; r++) hold[r] = 1'b0;
  endtask

  task automatic add_burst(int r, int len);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt.data = 8'($urandom);
      bt.last = (b == len - 1);
      prod_q[r].push_back(bt);
    end
  endtask

  // One cycle: drive producers, predict the outcome, push expectations.
  // full_mode: 0 = not full, 1 = full, 2 = random
  task automatic step(int full_mode, logic [N-1:0] stall);
    logic [N-1:0] v;
    int    cand;
    bit    served;
    bit    full;
    stat_t s;
    beat_t bt;
    @(posedge clk);
    #1;
    full = (full_mode == 1) || (full_mode == 2 && $urandom_range(3) == 0);
    for (int r = 0; r < N; r++) begin
      v[r] = (prod_q[r].size() > 0) && (hold[r] || !stall[r]);
      req_valid[r] = v[r];
      req_last[r]  = v[r] ? prod_q[r][0].last : 1'b0;
      req_data[r*DW +: DW] = v[r] ? prod_q[r][0].data : 8'($urandom);
    end
    fifo_full = full;

    cand = -1;
    if (m_owner >= 0) cand = m_owner;
    else begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (cand < 0 && v[j]) cand = j;
      end
    end
    served = (cand >= 0) && v[cand] && !full;

    s.wr    = served;
    s.idx   = cand;
    s.grant = m_grant;
    s.busy  = (m_owner >= 0);
    stat_q.push_back(s);

    for (int r = 0; r < N; r++) hold[r] = v[r] && !(served && r == cand);

    if (served) begin
      bt = prod_q[cand].pop_front();
      wdata_q.push_back(bt.data);
      m_grant = cand;
      m_beats++;
      if (bt.last || m_beats == MB) begin
        m_last  = cand;
        m_owner = -1;
        m_beats = 0;
      end else begin
        m_owner = cand;
      end
    end
  endtask

  function automatic int pending();
    int t;
    t = 0;
    for (int r = 0; r < N; r++) t += prod_q[r].size();
    return t;
  endfunction

  // Run with the FIFO draining until every producer is empty (bounded)
  task automatic drain();
    int guard;
    guard = 0;
    while (guard < 200 && (pending() > 0 || m_owner >= 0)) begin
      step(0, '0);
      guard++;
    end
    chk("drain_remaining", pending(), 0);
  endtask

  // Monitor: compare the DUT against the expectation for the current cycle
  always @(negedge clk) begin
    if (!rst && stat_q.size() > 0) begin
      stat_t         s;
      logic [N-1:0]  exp_rdy;
      logic [DW-1:0] d;
      s = stat_q.pop_front();
      exp_rdy = s.wr ? (N'(1) << s.idx) : '0;
      chk("wr_en", 32'(fifo_wr_en), 32'(s.wr));
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("grant_id", 32'(grant_id), s.grant);
      chk("busy", 32'(busy), 32'(s.busy));
      if (s.wr) begin
        d = wdata_q.pop_front();
        chk("wr_data", 32'(fifo_wr_data), 32'(d));
        $display("t=%0t write req%0d data=%02h busy=%0b grant_id=%0d",
                 $time, s.idx, fifo_wr_data, busy, grant_id);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    model_reset();

    // Reset state, with valids asserted to show ready/wr_en are forced low
    repeat (3) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Idle with no requests
    repeat (2) step(0, '0);

    // All four single-beat requesters: service order 0,1,2,3,0,1,2,3
    for (int r = 0; r < N; r++) begin
      add_burst(r, 1);
      add_burst(r, 1);
    end
    repeat (8) step(0, '0);
    drain();

    // 6-beat burst truncated at MAX_BURST, req2 interleaves
    add_burst(1, 6);
    add_burst(2, 1);
    drain();

    // Locked owner req0 stalled by full for 3 cycles, req3 must wait
    add_burst(0, 3);
    step(0, '0);
    add_burst(3, 1);
    repeat (3) step(1, '0);
    drain();

    // Owner req3 drops valid for 2 cycles mid-burst, req1 stays blocked
    add_burst(3, 3);
    step(0, '0);
    add_burst(1, 1);
    repeat (2) step(0, 4'b1000);
    drain();

    // Reset while req2 is locked with two beats accepted
    add_burst(2, 4);
    step(0, '0);
    step(0, '0);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_ready", 32'(req_ready), 0);
    chk("async_rst_wr_en", 32'(fifo_wr_en), 0);
    chk("async_rst_grant", 32'(grant_id), 0);
    for (int r = 0; r < N; r++) prod_q[r].delete();
    req_valid = '0;
    req_last  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    add_burst(3, 1);
    add_burst(0, 1);
    drain();

    // Randomized traffic with random full and producer gaps
    repeat (400) begin
      logic [N-1:0] stall;
      if ($urandom_range(2) == 0) begin
        int r;
        r = $urandom_range(N - 1);
        if (prod_q[r].size() < 12) add_burst(r, $urandom_range(6, 1));
      end
      for (int r = 0; r < N; r++) stall[r] = ($urandom_range(4) == 0);
      step(2, stall);
    end
    drain();

    @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(stat_q.size() + wdata_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
